// File: rtl/gpr_file.sv
// 32-entry general-purpose register file with a load-use busy scoreboard and stall output.
// Define GPR_BYPASS_EN to forward same-cycle write-back data and release stalls in the write-back cycle.
module gpr_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              ruse1,
  input  logic              ruse2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mark,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic [ADDR_W:0]   busy_pop;
  logic              wr_ok;
  logic              byp1;
  logic              byp2;
  logic              hit1;
  logic              hit2;

  assign wr_ok = we && (waddr != '0);

`ifdef GPR_BYPASS_EN
  assign byp1 = wr_ok && (waddr == raddr1);
  assign byp2 = wr_ok && (waddr == raddr2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = byp1 ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2 = byp2 ? wdata : regs[raddr2];
  end

  // A forwarded write satisfies the reader, so it masks that register's busy hit.
  assign hit1  = busy[raddr1] && (raddr1 != '0) && !byp1;
  assign hit2  = busy[raddr2] && (raddr2 != '0) && !byp2;
  assign stall = (ruse1 && hit1) || (ruse2 && hit2);

  // Mark beats a same-cycle write-back: the newer producer is still outstanding.
  always_comb begin
    busy_next = busy;
    for (int n = 1; n < NREG; n++) begin
      if (mark && (mark_addr == ADDR_W'(n))) busy_next[n] = 1'b1;
      else if (we && (waddr == ADDR_W'(n))) busy_next[n] = 1'b0;
    end
    busy_next[0] = 1'b0;
  end

  always_comb begin
    busy_pop = '0;
    for (int n = 1; n < NREG; n++) busy_pop = busy_pop + (ADDR_W+1)'(busy[n]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREG; n++) regs[n] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) regs[waddr] <= wdata;
      busy     <= busy_next;
      busy_cnt <= busy_pop;
    end
  end

endmodule
